// File: rtl/i2s_rx_stereo.sv
// Stereo I2S receiver: oversamples sck/ws/data on the system clock, assembles
// left/right words and presents them as one frame over a valid/ready handshake.
module i2s_rx_stereo #(
  parameter int DATA_WIDTH  = 24,
  parameter int LSB_FIRST   = 0,
  parameter int I2S_DELAY   = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  sck,
  input  logic                  ws,
  input  logic                  serial_in,
  output logic [DATA_WIDTH-1:0] left_data,
  output logic [DATA_WIDTH-1:0] right_data,
  output logic                  frame_valid,
  input  logic                  frame_ready,
  output logic                  overrun
);

  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DATA_WIDTH);
  localparam logic [DATA_WIDTH-1:0] LSB_ONE = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [DATA_WIDTH-1:0] MSB_ONE = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, LEFT, RIGHT} state_t;

  logic [SYNC_STAGES-1:0] sck_sync_q, ws_sync_q, sd_sync_q;
  logic                   sck_last_q;
  logic                   ev_q, ws_ev_q, sd_ev_q;
  logic                   ws_prev_q, ch_prev_q;
  state_t                 state_q, state_d;
  logic [DATA_WIDTH-1:0]  shift_q, shift_d;
  logic [DATA_WIDTH-1:0]  lword_q, lword_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]  left_q, left_d, right_q, right_d;
  logic                   valid_q, valid_d, ovr_q, ovr_d;
  logic                   ch, boundary, commit;

  // Slot words start cleared, so placing a bit is a plain OR of a one-hot mask.
  function automatic logic [DATA_WIDTH-1:0] place(input logic [DATA_WIDTH-1:0] w,
                                                  input logic [CW-1:0] k,
                                                  input logic b);
    logic [DATA_WIDTH-1:0] m;
    m = (LSB_FIRST != 0) ? (LSB_ONE << k) : (MSB_ONE >> k);
    return b ? (w | m) : w;
  endfunction

  assign ch       = (I2S_DELAY != 0) ? ws_prev_q : ws_ev_q;
  assign boundary = (ch != ch_prev_q);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sck_sync_q <= '0;
      ws_sync_q  <= '0;
      sd_sync_q  <= '0;
      sck_last_q <= 1'b0;
      ev_q       <= 1'b0;
      ws_ev_q    <= 1'b0;
      sd_ev_q    <= 1'b0;
      ws_prev_q  <= 1'b0;
      ch_prev_q  <= 1'b0;
    end else begin
      sck_sync_q <= {sck_sync_q[SYNC_STAGES-2:0], sck};
      ws_sync_q  <= {ws_sync_q[SYNC_STAGES-2:0], ws};
      sd_sync_q  <= {sd_sync_q[SYNC_STAGES-2:0], serial_in};
      sck_last_q <= sck_sync_q[SYNC_STAGES-1];
      ev_q       <= sck_sync_q[SYNC_STAGES-1] & ~sck_last_q;
      ws_ev_q    <= ws_sync_q[SYNC_STAGES-1];
      sd_ev_q    <= sd_sync_q[SYNC_STAGES-1];
      if (ev_q) begin
        ws_prev_q <= ws_ev_q;
        ch_prev_q <= ch;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    lword_d = lword_q;
    commit  = 1'b0;
    if (!enable) begin
      state_d = IDLE;
      shift_d = '0;
      cnt_d   = '0;
    end else if (ev_q) begin
      case (state_q)
        IDLE: begin
          if (boundary && !ch) begin
            state_d = LEFT;
            shift_d = place('0, '0, sd_ev_q);
            cnt_d   = CW'(1);
          end
        end
        LEFT, RIGHT: begin
          if (boundary) begin
            // Into right latches the left word; into left commits the frame.
            if (state_q == LEFT) lword_d = shift_q;
            else                 commit  = 1'b1;
            state_d = (state_q == LEFT) ? RIGHT : LEFT;
            shift_d = place('0, '0, sd_ev_q);
            cnt_d   = CW'(1);
          end else if (cnt_q < CNT_MAX) begin
            shift_d = place(shift_q, cnt_q, sd_ev_q);
            cnt_d   = cnt_q + CW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    left_d  = left_q;
    right_d = right_q;
    valid_d = valid_q;
    ovr_d   = 1'b0;
    if (commit) begin
      left_d  = lword_q;
      right_d = shift_q;
      valid_d = 1'b1;
      ovr_d   = valid_q & ~frame_ready;
    end else if (valid_q && frame_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      lword_q <= '0;
      cnt_q   <= '0;
      left_q  <= '0;
      right_q <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      lword_q <= lword_d;
      cnt_q   <= cnt_d;
      left_q  <= left_d;
      right_q <= right_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign left_data   = left_q;
  assign right_data  = right_q;
  assign frame_valid = valid_q;
  assign overrun     = ovr_q;

endmodule
